heap_arbiter: RTL and testbench

Shares one single-port heap memory between NReq requesters, such as the program engine and a dump/debug port, using a valid/ready request and a one-cycle response strobe. It converts (array, index) pairs into heap addresses (array*NArea + index) and range-checks them. It keeps the per-array length table that is currently updated inline by the program, and replaces the hand-toggled heap clock with a properly sequenced access on the system clock.

---
 rtl/heap_pkg.sv | 27 ++
 rtl/heap_ram.sv | 36 +++
 rtl/heap_arbiter.sv | 154 +++++++++++++++
 tb/tb_heap_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// ============================================================================
// Module   : heap_pkg
// Brief    : Shared sizing defaults, address-width helper and FSM encoding
//            for the heap arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package heap_pkg;

    localparam int DEF_MEMORY_ELEMENT_WIDTH = 12;
    localparam int DEF_N_AREA               = 4;
    localparam int DEF_N_ARRAYS             = 2;

    function automatic int heap_addr_width(input int n_arrays, input int n_area);
        return (n_arrays * n_area > 1) ? $clog2(n_arrays * n_area) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } heap_state_e;

endpackage

`default_nettype wire

// File: rtl/heap_ram.sv
// ============================================================================
// Module   : heap_ram
// Brief    : Single-port synchronous RAM, write-first, one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_ram #(
    parameter int DW    = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_o       <= wdata_i;
            end else begin
                rdata_o       <= mem_q[addr_i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/heap_arbiter.sv
// ============================================================================
// Module   : heap_arbiter
// Brief    : Round-robin arbiter sharing one heap RAM between requesters, with
//            (array,index) addressing, range check and per-array length table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_arbiter
    import heap_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_MEMORY_ELEMENT_WIDTH,
    parameter int NArea              = DEF_N_AREA,
    parameter int NArrays            = DEF_N_ARRAYS,
    parameter int NReq               = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NReq-1:0]                 req_valid,
    output logic [NReq-1:0]                 req_ready,
    input  logic [NReq-1:0]                 req_write,
    input  logic [NReq*MemoryElementWidth-1:0] req_array,
    input  logic [NReq*MemoryElementWidth-1:0] req_index,
    input  logic [NReq*MemoryElementWidth-1:0] req_data,
    output logic [NReq-1:0]                 resp_valid,
    output logic                            resp_error,
    output logic [MemoryElementWidth-1:0]   resp_data,
    input  logic                            clear_valid,
    input  logic [MemoryElementWidth-1:0]   clear_array,
    input  logic [MemoryElementWidth-1:0]   len_array,
    output logic [MemoryElementWidth-1:0]   len_out
);

    localparam int W  = MemoryElementWidth;
    localparam int AW = heap_addr_width(NArrays, NArea);
    localparam int SW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam int PW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam logic [W-1:0] C_N_ARRAYS = W'(NArrays);
    localparam logic [W-1:0] C_N_AREA   = W'(NArea);

    heap_state_e   state_q, state_d;
    logic [PW-1:0] rr_q, gid_q, gnt_id;
    logic          gnt_any, w_accept, w_err, ram_en;
    logic          write_q, kill_q, err_q;
    logic [W-1:0]  arr_q, idx_q, data_q, ram_rdata;
    logic [W-1:0]  len_q [NArrays];
    logic [AW-1:0] ram_addr;
    logic [W:0]    w_need;

    // Search starts at the round-robin pointer so the last winner yields next time.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = rr_q;
        for (int k = 0; k < NReq; k++) begin
            if (!gnt_any && req_valid[(int'(rr_q) + k) % NReq]) begin
                gnt_any = 1'b1;
                gnt_id  = PW'((int'(rr_q) + k) % NReq);
            end
        end
    end

    assign w_accept = (state_q == IDLE) && gnt_any;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_accept) state_d = ACCESS;
            ACCESS:  state_d = RESPOND;
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_q    <= '0;
            gid_q   <= '0;
            write_q <= 1'b0;
            arr_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (w_accept) begin
                gid_q   <= gnt_id;
                write_q <= req_write[gnt_id];
                arr_q   <= req_array[gnt_id*W +: W];
                idx_q   <= req_index[gnt_id*W +: W];
                data_q  <= req_data[gnt_id*W +: W];
                // A clear arriving with the accept must still beat the later length update.
                kill_q  <= clear_valid && (clear_array == req_array[gnt_id*W +: W]);
                rr_q    <= (gnt_id == PW'(NReq - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state_q == ACCESS) err_q <= w_err;
        end
    end

    assign w_err    = (arr_q >= C_N_ARRAYS) || (idx_q >= C_N_AREA);
    assign ram_en   = (state_q == ACCESS) && !w_err;
    assign ram_addr = AW'(arr_q[AW-1:0] * AW'(NArea) + idx_q[AW-1:0]);
    assign w_need   = {1'b0, idx_q} + (W+1)'(1);

    heap_ram #(
        .DW    (W),
        .DEPTH (NArrays * NArea),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .en_i    (ram_en),
        .we_i    (write_q),
        .addr_i  (ram_addr),
        .wdata_i (data_q),
        .rdata_o (ram_rdata)
    );

    // Clear is applied last so it wins over a same-cycle length update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NArrays; i++) len_q[i] <= '0;
        end else begin
            if (ram_en && write_q && !kill_q && (w_need > {1'b0, len_q[arr_q[SW-1:0]]}))
                len_q[arr_q[SW-1:0]] <= w_need[W-1:0];
            if (clear_valid && (clear_array < C_N_ARRAYS))
                len_q[clear_array[SW-1:0]] <= '0;
        end
    end

    assign len_out = (len_array < C_N_ARRAYS) ? len_q[len_array[SW-1:0]] : '0;

    always_comb begin
        resp_valid = '0;
        resp_error = 1'b0;
        resp_data  = '0;
        if (state_q == RESPOND) begin
            resp_valid[gid_q] = 1'b1;
            resp_error        = err_q;
            resp_data         = err_q ? '0 : ram_rdata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_heap_arbiter.sv
// ============================================================================
// Module   : tb_heap_arbiter
// Brief    : Directed self-checking bench for heap_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_heap_arbiter;

    localparam int W = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_ready, req_write, resp_valid;
    logic [2*W-1:0]  req_array, req_index, req_data;
    logic            resp_error;
    logic [W-1:0]    resp_data;
    logic            clear_valid;
    logic [W-1:0]    clear_array, len_array, len_out;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    heap_arbiter dut (
        .clock       (clk),
        .reset       (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_array   (req_array),
        .req_index   (req_index),
        .req_data    (req_data),
        .resp_valid  (resp_valid),
        .resp_error  (resp_error),
        .resp_data   (resp_data),
        .clear_valid (clear_valid),
        .clear_array (clear_array),
        .len_array   (len_array),
        .len_out     (len_out)
    );

    // Drives one request on requester r; returns response data/error and the
    // number of cycles from acceptance to resp_valid (-1 if never accepted).
    task automatic xfer(input int r, input bit wr, input logic [W-1:0] a,
                        input logic [W-1:0] i, input logic [W-1:0] d,
                        input bit clr, input logic [W-1:0] clr_a,
                        output logic [W-1:0] rd, output logic er, output int lat);
        int n = 0;
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        req_valid[r] = 1'b1; req_write[r] = wr;
        req_array[r*W +: W] = a; req_index[r*W +: W] = i; req_data[r*W +: W] = d;
        clear_valid = clr; clear_array = clr_a;
        #1;
        while (!req_ready[r] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready[r]) begin
            @(negedge clk);
            req_valid[r] = 1'b0; clear_valid = 1'b0;
            lat = 1;
            while (!resp_valid[r] && lat < 10) begin
                @(negedge clk); lat++;
            end
            if (resp_valid[r]) begin
                rd = resp_data; er = resp_error;
            end else begin
                lat = -1;
            end
        end else begin
            req_valid[r] = 1'b0; clear_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        len_array = 12'd1;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_error, resp_data, len_out} !== '0)
            $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b data=%0d len=%0d, want all 0",
                     req_ready, resp_valid, resp_error, resp_data, len_out);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 2'b00 || len_out !== 12'd0)
            $display("FAIL reset_release: got rv=%b len=%0d, want 0 0", resp_valid, len_out);
        else pass_cnt++;
    endtask

    task automatic test_write_basic();
        logic [W-1:0] rd; logic er; int lat;
        xfer(0, 1'b1, 12'd1, 12'd0, 12'd11, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 12'd11 || er !== 1'b0)
            $display("FAIL write_1_0: got lat=%0d data=%0d err=%b, want lat=2 data=11 err=0", lat, rd, er);
        else pass_cnt++;
        xfer(0, 1'b1, 12'd1, 12'd1, 12'd22, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 12'd22 || er !== 1'b0)
            $display("FAIL write_1_1: got lat=%0d data=%0d err=%b, want lat=2 data=22 err=0", lat, rd, er);
        else pass_cnt++;
        len_array = 12'd1; #1;
        total++;
        if (len_out !== 12'd2) $display("FAIL len_after_writes: got %0d want 2", len_out);
        else pass_cnt++;
    endtask

    task automatic test_read_sum();
        logic [W-1:0] r1, r0, rs, s; logic er; int lat;
        xfer(0, 1'b0, 12'd1, 12'd1, 12'd0, 1'b0, 12'd0, r1, er, lat);
        total++;
        if (lat !== 2 || r1 !== 12'd22 || er !== 1'b0)
            $display("FAIL read_1_1: got lat=%0d data=%0d err=%b, want lat=2 data=22 err=0", lat, r1, er);
        else pass_cnt++;
        xfer(0, 1'b0, 12'd1, 12'd0, 12'd0, 1'b0, 12'd0, r0, er, lat);
        total++;
        if (r0 !== 12'd11 || er !== 1'b0)
            $display("FAIL read_1_0: got data=%0d err=%b, want data=11 err=0", r0, er);
        else pass_cnt++;
        s = r1 + r0;
        xfer(0, 1'b1, 12'd1, 12'd2, s, 1'b0, 12'd0, rs, er, lat);
        xfer(0, 1'b0, 12'd1, 12'd2, 12'd0, 1'b0, 12'd0, rs, er, lat);
        total++;
        if (rs !== 12'd33) $display("FAIL read_sum: got %0d want 33", rs);
        else pass_cnt++;
        len_array = 12'd1; #1;
        total++;
        if (len_out !== 12'd3) $display("FAIL len_after_sum: got %0d want 3", len_out);
        else pass_cnt++;
    endtask

    // Earlier traffic all came from requester 0, so the pointer now favours 1.
    task automatic test_alternate();
        int cnt [2];
        int g;
        logic [1:0] exp_g;
        logic [W-1:0] exp_d [2][4];
        bit           wr_t  [2][4];
        logic [W-1:0] arr_t [2];
        for (int k = 0; k < 4; k++) begin
            exp_d[0][k] = 12'd100 + 12'(k); wr_t[0][k] = 1'b1;
            wr_t[1][k]  = (k == 3);
        end
        exp_d[1][0] = 12'd11; exp_d[1][1] = 12'd22; exp_d[1][2] = 12'd33; exp_d[1][3] = 12'd44;
        arr_t[0] = 12'd0; arr_t[1] = 12'd1;
        cnt[0] = 0; cnt[1] = 0;
        exp_g = 2'd1;
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            req_valid[r] = 1'b1; req_write[r] = wr_t[r][0];
            req_array[r*W +: W] = arr_t[r]; req_index[r*W +: W] = 12'd0;
            req_data[r*W +: W] = exp_d[r][0];
        end
        for (int n = 0; n < 8; n++) begin
            if (n > 0) @(negedge clk);
            #1;
            total++;
            if (req_ready !== (2'b01 << exp_g))
                $display("FAIL grant_%0d: got ready=%b want %b", n, req_ready, 2'b01 << exp_g);
            else pass_cnt++;
            g = int'(exp_g);
            @(negedge clk);
            cnt[g]++;
            if (cnt[g] < 4) begin
                req_write[g] = wr_t[g][cnt[g]];
                req_index[g*W +: W] = 12'(cnt[g]);
                req_data[g*W +: W] = exp_d[g][cnt[g]];
            end else begin
                req_valid[g] = 1'b0;
            end
            @(negedge clk);
            total++;
            if (resp_valid !== (2'b01 << exp_g) || resp_data !== exp_d[g][cnt[g]-1])
                $display("FAIL resp_%0d: got rv=%b data=%0d want rv=%b data=%0d",
                         n, resp_valid, resp_data, 2'b01 << exp_g, exp_d[g][cnt[g]-1]);
            else pass_cnt++;
            exp_g = 2'd1 - exp_g;
        end
        len_array = 12'd0; #1;
        total++;
        if (len_out !== 12'd4) $display("FAIL len_arr0_alt: got %0d want 4", len_out);
        else pass_cnt++;
        len_array = 12'd1; #1;
        total++;
        if (len_out !== 12'd4) $display("FAIL len_arr1_alt: got %0d want 4", len_out);
        else pass_cnt++;
    endtask

    task automatic test_range_error();
        logic [W-1:0] rd; logic er; int lat;
        xfer(0, 1'b1, 12'd2, 12'd0, 12'd55, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 1'b1 || rd !== 12'd0)
            $display("FAIL err_write_arr2: got lat=%0d err=%b data=%0d want 2 1 0", lat, er, rd);
        else pass_cnt++;
        xfer(1, 1'b0, 12'd0, 12'd4, 12'd0, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (lat !== 2 || er !== 1'b1 || rd !== 12'd0)
            $display("FAIL err_read_idx4: got lat=%0d err=%b data=%0d want 2 1 0", lat, er, rd);
        else pass_cnt++;
        xfer(0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (rd !== 12'd100 || er !== 1'b0)
            $display("FAIL heap_unchanged: got data=%0d err=%b want 100 0", rd, er);
        else pass_cnt++;
        len_array = 12'd0; #1;
        total++;
        if (len_out !== 12'd4) $display("FAIL len_unchanged: got %0d want 4", len_out);
        else pass_cnt++;
        len_array = 12'd2; #1;
        total++;
        if (len_out !== 12'd0) $display("FAIL len_out_of_range: got %0d want 0", len_out);
        else pass_cnt++;
    endtask

    task automatic test_clear_collision();
        logic [W-1:0] rd; logic er; int lat;
        xfer(0, 1'b1, 12'd1, 12'd3, 12'd77, 1'b1, 12'd1, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 12'd77)
            $display("FAIL clear_write_echo: got lat=%0d data=%0d want 2 77", lat, rd);
        else pass_cnt++;
        len_array = 12'd1; #1;
        total++;
        if (len_out !== 12'd0) $display("FAIL clear_wins: got len=%0d want 0", len_out);
        else pass_cnt++;
        xfer(0, 1'b0, 12'd1, 12'd3, 12'd0, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (rd !== 12'd77) $display("FAIL clear_data_kept: got %0d want 77", rd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        logic [W-1:0] rd; logic er; int lat;
        bit seen = 1'b0;
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b0;
        req_array[0 +: W] = 12'd0; req_index[0 +: W] = 12'd1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst = 1'b1;
        len_array = 12'd0;
        #1;
        total++;
        if ({req_ready, resp_valid, resp_error, resp_data, len_out} !== '0)
            $display("FAIL reset_mid: got rdy=%b rv=%b err=%b data=%0d len=%0d want all 0",
                     req_ready, resp_valid, resp_error, resp_data, len_out);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 2'b00) seen = 1'b1;
        end
        total++;
        if (seen) $display("FAIL reset_no_resp: got a response after reset, want none");
        else pass_cnt++;
        xfer(0, 1'b0, 12'd0, 12'd1, 12'd0, 1'b0, 12'd0, rd, er, lat);
        total++;
        if (lat !== 2 || rd !== 12'd101 || er !== 1'b0)
            $display("FAIL after_reset_read: got lat=%0d data=%0d err=%b want 2 101 0", lat, rd, er);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0;
        req_array = '0; req_index = '0; req_data = '0;
        clear_valid = 1'b0; clear_array = '0; len_array = '0;
        test_reset();
        test_write_basic();
        test_read_sum();
        test_alternate();
        test_range_error();
        test_clear_collision();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

`default_nettype wire
